// File: rtl/uart_pkg.sv
// Shared UART definitions: TX state encoding, serial line levels and parity-type codes.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_tx_parity_calc.sv
// Parity of a data word, even or odd, matching the uart_rx parity check.
// Latency: combinational. Backpressure: none.
module uart_tx_parity_calc
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  par_typ,
  output logic                  parity
);

  assign parity = (par_typ == PAR_ODD) ? ~^data : ^data;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter, one clk per serial bit: start, DATA_WIDTH bits LSB first, optional parity, stop.
// Latency: start bit on the edge after accept. Backpressure: data_valid ignored while busy, no queue.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  data_valid,
  input  logic                  par_en,
  input  logic                  par_typ,
  output logic                  tx_out,
  output logic                  busy
);

  localparam int CNT_W = $clog2(DATA_WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  tx_state_t             state, state_n;
  logic [CNT_W-1:0]      bit_cnt, bit_cnt_n;
  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] data_shifted;
  logic                  par_en_q, par_typ_q;
  logic                  accept;
  logic                  parity;
  logic                  tx_n, busy_n;

  assign accept = (state == IDLE) && data_valid;

  uart_tx_parity_calc #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_parity (
    .data   (data_q),
    .par_typ(par_typ_q),
    .parity (parity)
  );

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    case (state)
      IDLE:   if (data_valid) state_n = START;
      START: begin
        state_n   = DATA;
        bit_cnt_n = '0;
      end
      DATA: begin
        if (bit_cnt == LAST_BIT) state_n = par_en_q ? PARITY : STOP;
        else                     bit_cnt_n = bit_cnt + 1'b1;
      end
      PARITY: state_n = STOP;
      STOP:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the pin and busy come straight from flops.
  always_comb begin
    data_shifted = data_q >> bit_cnt_n;
    tx_n         = LINE_IDLE;
    busy_n       = (state_n != IDLE);
    case (state_n)
      START:  tx_n = START_BIT;
      DATA:   tx_n = data_shifted[0];
      PARITY: tx_n = parity;
      STOP:   tx_n = STOP_BIT;
      default: tx_n = LINE_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      tx_out    <= LINE_IDLE;
      busy      <= 1'b0;
    end else begin
      state   <= state_n;
      bit_cnt <= bit_cnt_n;
      tx_out  <= tx_n;
      busy    <= busy_n;
      if (accept) begin
        data_q    <= p_data;
        par_en_q  <= par_en;
        par_typ_q <= par_typ;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at DATA_WIDTH 8 and 5: frame vectors from a table plus multi-cycle corner sequences.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] p8;
  logic [4:0] p5;
  logic       dv8, dv5, par_en, par_typ;
  logic       tx8, busy8, tx5, busy5;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  uart_tx #(.DATA_WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .p_data(p8), .data_valid(dv8),
    .par_en(par_en), .par_typ(par_typ), .tx_out(tx8), .busy(busy8)
  );

  uart_tx #(.DATA_WIDTH(5)) dut5 (
    .clk(clk), .rst(rst), .p_data(p5), .data_valid(dv5),
    .par_en(par_en), .par_typ(par_typ), .tx_out(tx5), .busy(busy5)
  );

  typedef struct {
    string      name;
    bit         sel;   // 0 = 8-bit instance, 1 = 5-bit instance
    logic [7:0] data;
    logic       pe;
    logic       pt;
    int         len;
    logic [15:0] exp;  // bit i = expected tx_out in frame cycle i
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  // Pulses data_valid for one accept edge, then records 16 cycles of tx_out/busy.
  task automatic frame(input bit sel, input logic [7:0] d, input logic pe, input logic pt,
                       output logic [15:0] txv, output logic [15:0] bv);
    p8 = d; p5 = d[4:0]; par_en = pe; par_typ = pt;
    if (sel) dv5 = 1'b1; else dv8 = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      dv8 = 1'b0; dv5 = 1'b0;
      txv[i] = sel ? tx5 : tx8;
      bv[i]  = sel ? busy5 : busy8;
    end
  endtask

  initial begin
    logic [15:0] txv, bv, exp_tx, exp_b;
    logic [31:0] tx32, b32;

    vecs[0] = '{"w8_a5_nopar",  1'b0, 8'hA5, 1'b0, 1'b0, 10, 16'h034A};
    vecs[1] = '{"w8_a5_even",   1'b0, 8'hA5, 1'b1, 1'b0, 11, 16'h054A};
    vecs[2] = '{"w8_a5_odd",    1'b0, 8'hA5, 1'b1, 1'b1, 11, 16'h074A};
    vecs[3] = '{"w8_01_nopar",  1'b0, 8'h01, 1'b0, 1'b0, 10, 16'h0202};
    vecs[4] = '{"w8_80_odd",    1'b0, 8'h80, 1'b1, 1'b1, 11, 16'h0500};
    vecs[5] = '{"w8_7f_even",   1'b0, 8'h7F, 1'b1, 1'b0, 11, 16'h06FE};
    vecs[6] = '{"w5_15_nopar",  1'b1, 8'h15, 1'b0, 1'b0,  7, 16'h006A};
    vecs[7] = '{"w5_15_even",   1'b1, 8'h15, 1'b1, 1'b0,  8, 16'h00EA};
    vecs[8] = '{"w5_15_odd",    1'b1, 8'h15, 1'b1, 1'b1,  8, 16'h00AA};
    vecs[9] = '{"w5_0c_odd",    1'b1, 8'h0C, 1'b1, 1'b1,  8, 16'h00D8};

    // Reset held with data_valid asserted: line stays idle, nothing starts.
    rst = 1'b1; dv8 = 1'b1; dv5 = 1'b1; p8 = 8'hA5; p5 = 5'h15; par_en = 1'b0; par_typ = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("reset_hold", {28'd0, tx8, busy8, tx5, busy5}, 32'hA);
    end
    rst = 1'b0; dv8 = 1'b0; dv5 = 1'b0;
    @(posedge clk); #1;
    check("post_reset_idle", {28'd0, tx8, busy8, tx5, busy5}, 32'hA);

    foreach (vecs[k]) begin
      frame(vecs[k].sel, vecs[k].data, vecs[k].pe, vecs[k].pt, txv, bv);
      exp_tx = vecs[k].exp | (16'hFFFF << vecs[k].len);
      exp_b  = ~(16'hFFFF << vecs[k].len);
      check({vecs[k].name, "_tx"},   {16'd0, txv}, {16'd0, exp_tx});
      check({vecs[k].name, "_busy"}, {16'd0, bv},  {16'd0, exp_b});
    end

    // Held data_valid: 0x00 then 0xFF, p_data flipped mid-frame each time.
    par_en = 1'b0; par_typ = 1'b0; p8 = 8'h00; dv8 = 1'b1;
    for (int i = 0; i < 32; i++) begin
      @(posedge clk); #1;
      tx32[i] = tx8; b32[i] = busy8;
      if (i == 2)  p8 = 8'hFF;
      if (i == 11) dv8 = 1'b0;
      if (i == 14) p8 = 8'h00;
    end
    check("b2b_tx",   tx32, 32'hFFFFF600);
    check("b2b_busy", b32,  32'h001FFBFF);

    // New request while in DATA is dropped; the frame in flight is unchanged.
    p8 = 8'h81; dv8 = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      txv[i] = tx8; bv[i] = busy8;
      dv8 = (i == 2 || i == 3);
      if (i == 2) p8 = 8'h3C;
    end
    check("busy_ignore_tx",   {16'd0, txv}, 32'h0000FF02);
    check("busy_ignore_busy", {16'd0, bv},  32'h000003FF);

    // Reset while DATA bit 4 is on the line aborts the frame.
    p8 = 8'hA5; dv8 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      dv8 = 1'b0;
    end
    check("abort_pre_bit4", {31'd0, tx8}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_reset_edge", {30'd0, tx8, busy8}, 32'h2);
    rst = 1'b0;
    @(posedge clk); #1;
    check("abort_idle_after", {30'd0, tx8, busy8}, 32'h2);
    frame(1'b0, 8'h3C, 1'b1, 1'b0, txv, bv);
    check("abort_next_tx",   {16'd0, txv}, 32'h0000FC78);
    check("abort_next_busy", {16'd0, bv},  32'h000007FF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
